data_mem_arbiter: RTL and testbench

//  Shares the single Data_Memory port between two requesters: port 0 (CPU MEM stage)
//  and port 1 (loader/debug master). Req/ack handshake per port with round-robin

---
 rtl/data_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each granted request makes exactly one memory access: IDLE -> ACCESS -> DONE.
module data_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   output logic              ack0_o,
   output logic [DATA_W-1:0] rdata0_o,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              ack1_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [ADDR_W-1:0] memAddr_o,
   output logic [DATA_W-1:0] memData_o,
   output logic              memRead_o,
   output logic              memWrite_o,
   input  logic [DATA_W-1:0] memData_i,
   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q;
   logic                last_grant_q;
   logic [1:0]          grant_q;
   logic                ack0_q;
   logic                ack1_q;
   logic [DATA_W-1:0]   rdata0_q;
   logic [DATA_W-1:0]   rdata1_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_data_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic                win_d;

   // On a tie the port that did not win last time goes; otherwise whoever asks.
   always_comb begin
      win_d = req1_i;
      if (req0_i && req1_i) begin
         win_d = ~last_grant_q;
      end
   end

   // The memory-side registers double as the latched transaction during ACCESS.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 2'b00;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req0_i || req1_i) begin
                  grant_q     <= win_d ? 2'b10 : 2'b01;
                  mem_addr_q  <= win_d ? addr1_i : addr0_i;
                  mem_data_q  <= win_d ? wdata1_i : wdata0_i;
                  mem_write_q <= win_d ? we1_i : we0_i;
                  mem_read_q  <= win_d ? ~we1_i : ~we0_i;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (mem_read_q) begin
                  if (grant_q[1]) begin
                     rdata1_q <= memData_i;
                  end else begin
                     rdata0_q <= memData_i;
                  end
               end
               ack0_q      <= grant_q[0];
               ack1_q      <= grant_q[1];
               mem_addr_q  <= '0;
               mem_data_q  <= '0;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               state_q     <= DONE;
            end
            DONE: begin
               last_grant_q <= grant_q[1];
               grant_q      <= 2'b00;
               state_q      <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack0_o     = ack0_q;
   assign ack1_o     = ack1_q;
   assign rdata0_o   = rdata0_q;
   assign rdata1_o   = rdata1_q;
   assign grant_o    = grant_q;
   assign memAddr_o  = mem_addr_q;
   assign memData_o  = mem_data_q;
   assign memRead_o  = mem_read_q;
   assign memWrite_o = mem_write_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: transaction-level scheduling model plus
// a small behavioural data memory on the memory side.
module tb_data_mem_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } op_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        req0_i, we0_i, ack0_o, req1_i, we1_i, ack1_o;
   logic [31:0] addr0_i, wdata0_i, rdata0_o, addr1_i, wdata1_i, rdata1_o;
   logic [31:0] memAddr_o, memData_o, memData_i;
   logic        memRead_o, memWrite_o;
   logic [1:0]  grant_o;

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
      .ack0_o(ack0_o), .rdata0_o(rdata0_o),
      .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
      .ack1_o(ack1_o), .rdata1_o(rdata1_o),
      .memAddr_o(memAddr_o), .memData_o(memData_o), .memRead_o(memRead_o),
      .memWrite_o(memWrite_o), .memData_i(memData_i), .grant_o(grant_o)
   );

   always #5 clk_i = ~clk_i;

   // Environment memory standing in for Data_Memory (combinational read).
   logic [31:0] env_mem [16];
   assign memData_i = env_mem[memAddr_o[3:0]];
   always @(posedge clk_i) begin
      if (memWrite_o) env_mem[memAddr_o[3:0]] <= memData_o;
   end

   // Requester drivers
   logic dreq [2];
   op_t  cur [2];
   op_t  q0 [$];
   op_t  q1 [$];
   int   gen_pct [2];
   assign req0_i = dreq[0];  assign we0_i = cur[0].we;
   assign addr0_i = cur[0].addr;  assign wdata0_i = cur[0].wdata;
   assign req1_i = dreq[1];  assign we1_i = cur[1].we;
   assign addr1_i = cur[1].addr;  assign wdata1_i = cur[1].wdata;

   // Reference model: transactions are serialized, 3 cycles each
   logic [31:0] ref_mem [16];
   logic [31:0] exp_rdata [2];
   int   cyc, m_start, m_idle_from, m_win, m_last, n_txn [2];
   bit   m_valid;
   op_t  m_op;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int qsize(input int p);
      return (p == 0) ? q0.size() : q1.size();
   endfunction

   task automatic push(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      op_t o;
      o.we = we; o.addr = a; o.wdata = d;
      if (p == 0) q0.push_back(o); else q1.push_back(o);
   endtask

   task automatic model_reset();
      m_valid = 0; m_idle_from = 0; m_last = 1;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      for (int p = 0; p < 2; p++) begin dreq[p] = 1'b0; cur[p] = '0; end
      q0.delete(); q1.delete();
   endtask

   task automatic step();
      int         ph;
      logic [1:0] e_grant;
      logic       e_ack [2];
      logic       e_rd, e_wr;
      logic [31:0] e_addr, e_data;
      @(posedge clk_i); #1;
      cyc++;
      ph = m_valid ? (cyc - m_start) : 0;
      e_grant = 2'b00; e_ack[0] = 0; e_ack[1] = 0;
      e_rd = 0; e_wr = 0; e_addr = 0; e_data = 0;
      if (ph == 1 || ph == 2) e_grant = (m_win == 1) ? 2'b10 : 2'b01;
      if (ph == 1) begin
         e_wr = m_op.we; e_rd = ~m_op.we; e_addr = m_op.addr; e_data = m_op.wdata;
      end
      if (ph == 2) begin
         e_ack[m_win] = 1'b1;
         if (m_op.we) ref_mem[m_op.addr[3:0]] = m_op.wdata;
         else exp_rdata[m_win] = ref_mem[m_op.addr[3:0]];
         m_last = m_win;
         n_txn[m_win]++;
         $display("txn cyc=%0d port=%0d %s addr=0x%08h data=0x%08h", cyc, m_win,
                  m_op.we ? "WR" : "RD", m_op.addr,
                  m_op.we ? m_op.wdata : exp_rdata[m_win]);
      end
      check("grant", {30'd0, grant_o}, {30'd0, e_grant});
      check("ack0", {31'd0, ack0_o}, {31'd0, e_ack[0]});
      check("ack1", {31'd0, ack1_o}, {31'd0, e_ack[1]});
      check("memRead", {31'd0, memRead_o}, {31'd0, e_rd});
      check("memWrite", {31'd0, memWrite_o}, {31'd0, e_wr});
      check("memAddr", memAddr_o, e_addr);
      check("memData", memData_o, e_data);
      check("rdata0", rdata0_o, exp_rdata[0]);
      check("rdata1", rdata1_o, exp_rdata[1]);
      // Drivers: generate, retire on ack, present next queued op
      for (int p = 0; p < 2; p++) begin
         if (gen_pct[p] > 0 && qsize(p) == 0 && !dreq[p] &&
             $urandom_range(99) < gen_pct[p])
            push(p, 1'($urandom_range(1)), 32'($urandom_range(15)), $urandom);
         if (e_ack[p]) dreq[p] = 1'b0;
         if (!dreq[p] && qsize(p) > 0) begin
            cur[p] = (p == 0) ? q0.pop_front() : q1.pop_front();
            dreq[p] = 1'b1;
         end
      end
      if (cyc >= m_idle_from && (dreq[0] || dreq[1])) begin
         if (dreq[0] && dreq[1]) m_win = (m_last == 1) ? 0 : 1;
         else m_win = dreq[1] ? 1 : 0;
         m_op = cur[m_win];
         m_start = cyc; m_valid = 1; m_idle_from = cyc + 3;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || dreq[0] || dreq[1] || cyc < m_idle_from)
             && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) check("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int n;
      int base0, base1;
      for (int i = 0; i < 16; i++) begin
         logic [31:0] v;
         v = $urandom;
         env_mem[i] = v;
         ref_mem[i] = v;
      end
      gen_pct[0] = 0; gen_pct[1] = 0;
      n_txn[0] = 0; n_txn[1] = 0;
      cyc = 0; m_start = 0; m_win = 0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_grant", {30'd0, grant_o}, 32'd0);
      check("rst_memRead", {31'd0, memRead_o}, 32'd0);
      check("rst_memWrite", {31'd0, memWrite_o}, 32'd0);
      check("rst_ack", {30'd0, ack1_o, ack0_o}, 32'd0);
      check("rst_rdata0", rdata0_o, 32'd0);
      check("rst_rdata1", rdata1_o, 32'd0);
      #4 rst_i = 1'b1;

      // Idle: nothing may move
      repeat (20) step();

      // Simultaneous requests, continuous: strict alternation starting with port 0
      for (int k = 0; k < 3; k++) begin
         push(0, 1'b0, 32'd8, 32'd0);
         push(1, 1'b0, 32'd8, 32'd0);
      end
      drain(100);
      check("alt_count0", n_txn[0], 3);
      check("alt_count1", n_txn[1], 3);

      // Port 0 write then read back
      push(0, 1'b1, 32'd4, 32'h0000_00A5);
      push(0, 1'b0, 32'd4, 32'd0);
      drain(50);
      check("wr_rd_back", rdata0_o, 32'h0000_00A5);

      // Port 1 alone, back-to-back reads
      for (int a = 0; a < 4; a++) push(1, 1'b0, 32'(a), 32'd0);
      drain(50);

      // Randomized traffic at varying load
      base0 = n_txn[0]; base1 = n_txn[1];
      for (int r = 0; r < 4; r++) begin
         gen_pct[0] = (r == 3) ? 100 : 20 + 25 * r;
         gen_pct[1] = (r == 3) ? 100 : 70 - 20 * r;
         repeat (250) step();
      end
      gen_pct[0] = 0; gen_pct[1] = 0;
      drain(100);
      check("rand_progress", {31'd0, (n_txn[0] > base0 + 20) && (n_txn[1] > base1 + 20)}, 32'd1);

      // Reset during the ACCESS of a port 0 write
      push(0, 1'b1, 32'd12, 32'h0000_005A);
      n = 0;
      while (!(m_valid && cyc - m_start == 1) && n < 20) begin step(); n++; end
      if (n >= 20) check("access_timeout", 32'd1, 32'd0);
      check("pre_rst_memWrite", {31'd0, memWrite_o}, 32'd1);
      #3 rst_i = 1'b0;
      #1;
      check("async_memWrite", {31'd0, memWrite_o}, 32'd0);
      check("async_memRead", {31'd0, memRead_o}, 32'd0);
      check("async_grant", {30'd0, grant_o}, 32'd0);
      model_reset();
      repeat (2) step();
      #4 rst_i = 1'b1;
      check("mem12_unchanged", env_mem[12], ref_mem[12]);
      push(1, 1'b0, 32'd12, 32'd0);
      step();
      step();
      check("post_rst_grant", {30'd0, grant_o}, 32'd2);
      drain(50);
      check("post_rst_rdata1", rdata1_o, ref_mem[12]);
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
